// File: rtl/ram_writer.sv
// ram_writer: write-side front end for the 32K x 8 RAM.
// Takes a byte stream over a valid/ready handshake, or generates an
// incrementing fill pattern, and writes consecutive addresses starting at a
// programmable base.
// Ports:
//   clk, rst       clock and synchronous active-low reset
//   start, switch  begin a transfer (IDLE only); mode 0=stream, 1=fill
//   base_addr      first write address, latched at start
//   length         beats to write, clamped to 2**ADDR_W, latched at start
//   in_data        stream byte, or fill seed when start is taken
//   in_valid       stream byte valid
//   in_ready       writer accepts a stream byte this cycle
//   wr_en, address, data  registered RAM write port
//   busy, done     transfer active / one-cycle end pulse
//   count          beats accepted in the current or last transfer
module ram_writer #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              switch,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  count
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic              r_mode;
  logic [DATA_W-1:0] r_pattern;
  logic [LEN_W-1:0]  r_count;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_data;
  logic              r_done;
  logic              w_accept;
  logic              w_in_ready;
  logic              w_more;
  logic [LEN_W-1:0]  w_len_clamped;

  assign w_more        = (r_count < r_len);
  assign w_len_clamped = (length > MAX_LEN) ? MAX_LEN : length;

  // Next-state and acceptance decode
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_in_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_WRITE;
      end
      S_WRITE: begin
        if (!w_more) begin
          w_next_state = S_DONE;
        end else if (r_mode) begin
          // Fill mode: one implicit beat per cycle, stream input ignored
          w_accept = 1'b1;
        end else begin
          w_in_ready = 1'b1;
          w_accept   = in_valid;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Transfer context and registered write port
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_mode    <= 1'b0;
      r_pattern <= '0;
      r_count   <= '0;
      r_wr_en   <= 1'b0;
      r_address <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      r_done  <= (r_state == S_WRITE) && (w_next_state == S_DONE);
      if ((r_state == S_IDLE) && start) begin
        r_addr  <= base_addr;
        r_len   <= w_len_clamped;
        r_mode  <= switch;
        r_count <= '0;
        if (switch) r_pattern <= in_data;
      end
      if (w_accept) begin
        r_address <= r_addr;
        r_data    <= r_mode ? r_pattern : in_data;
        // Address and pattern wrap naturally at their register widths
        r_addr    <= r_addr + ADDR_W'(1);
        r_count   <= r_count + LEN_W'(1);
        if (r_mode) r_pattern <= r_pattern + DATA_W'(1);
      end
    end
  end

  assign in_ready = w_in_ready;
  assign wr_en    = r_wr_en;
  assign address  = r_address;
  assign data     = r_data;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign count    = r_count;

endmodule

// File: tb/tb_ram_writer.sv
// Directed bench for ram_writer: per-cycle vector table plus a long
// fill sequence exercising the length clamp.
module tb_ram_writer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        switch;
  logic [14:0] base_addr;
  logic [15:0] length;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [14:0] address;
  logic [7:0]  data;
  logic        busy;
  logic        done;
  logic [15:0] count;

  int n_vec;
  int n_err;

  ram_writer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .switch   (switch),
    .base_addr(base_addr),
    .length   (length),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .address  (address),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic        sw;
    logic [14:0] base;
    logic [15:0] len;
    logic [7:0]  din;
    logic        vld;
    logic        e_wr;
    logic [14:0] e_addr;
    logic [7:0]  e_data;
    logic        e_busy;
    logic        e_done;
    logic        e_rdy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic st, logic sw, logic [14:0] b,
                              logic [15:0] l, logic [7:0] d, logic v,
                              logic ew, logic [14:0] ea, logic [7:0] ed,
                              logic eb, logic edn, logic er, logic [15:0] ec);
    vec_t t;
    t.rst = r;  t.start = st; t.sw = sw; t.base = b; t.len = l;
    t.din = d;  t.vld = v;
    t.e_wr = ew; t.e_addr = ea; t.e_data = ed; t.e_busy = eb;
    t.e_done = edn; t.e_rdy = er; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    if (act != exp) begin
      n_err++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t t);
    n_vec++;
    chk("wr_en",    idx, int'(wr_en),    int'(t.e_wr));
    chk("address",  idx, int'(address),  int'(t.e_addr));
    chk("data",     idx, int'(data),     int'(t.e_data));
    chk("busy",     idx, int'(busy),     int'(t.e_busy));
    chk("done",     idx, int'(done),     int'(t.e_done));
    chk("in_ready", idx, int'(in_ready), int'(t.e_rdy));
    chk("count",    idx, int'(count),    int'(t.e_cnt));
  endtask

  initial begin
    vec_t rv;
    int   writes;
    int   bad_seq;
    logic [14:0] exp_a;
    logic [7:0]  last_d;
    logic [14:0] last_a;
    bit   seen_done;

    n_vec = 0;
    n_err = 0;

    // Stream, base 0x0010, 4 beats A1..A4
    vecs.push_back(mk(1,1,0,15'h0010,16'd4,8'h00,0, 0,15'h0000,8'h00,1,0,1,16'd0));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'hA1,1, 1,15'h0010,8'hA1,1,0,1,16'd1));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'hA2,1, 1,15'h0011,8'hA2,1,0,1,16'd2));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'hA3,1, 1,15'h0012,8'hA3,1,0,1,16'd3));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'hA4,1, 1,15'h0013,8'hA4,1,0,0,16'd4));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'hA5,1, 0,15'h0013,8'hA4,1,1,0,16'd4));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h00,0, 0,15'h0013,8'hA4,0,0,0,16'd4));
    // Fill with wrap, base 0x7FFE, seed 0xFE
    vecs.push_back(mk(1,1,1,15'h7FFE,16'd4,8'hFE,0, 0,15'h0013,8'hA4,1,0,0,16'd0));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h00,1, 1,15'h7FFE,8'hFE,1,0,0,16'd1));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h00,0, 1,15'h7FFF,8'hFF,1,0,0,16'd2));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h00,0, 1,15'h0000,8'h00,1,0,0,16'd3));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h00,0, 1,15'h0001,8'h01,1,0,0,16'd4));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h00,0, 0,15'h0001,8'h01,1,1,0,16'd4));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h00,0, 0,15'h0001,8'h01,0,0,0,16'd4));
    // Stream backpressure, base 0x0100, 3 beats, valid 1,0,0,1,0,1
    vecs.push_back(mk(1,1,0,15'h0100,16'd3,8'h00,0, 0,15'h0001,8'h01,1,0,1,16'd0));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h11,1, 1,15'h0100,8'h11,1,0,1,16'd1));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h22,0, 0,15'h0100,8'h11,1,0,1,16'd1));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h33,0, 0,15'h0100,8'h11,1,0,1,16'd1));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h44,1, 1,15'h0101,8'h44,1,0,1,16'd2));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h55,0, 0,15'h0101,8'h44,1,0,1,16'd2));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h66,1, 1,15'h0102,8'h66,1,0,0,16'd3));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h00,0, 0,15'h0102,8'h66,1,1,0,16'd3));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h00,0, 0,15'h0102,8'h66,0,0,0,16'd3));
    // Zero length: no write, done two cycles after start
    vecs.push_back(mk(1,1,0,15'h0200,16'd0,8'h00,0, 0,15'h0102,8'h66,1,0,0,16'd0));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h77,1, 0,15'h0102,8'h66,1,1,0,16'd0));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h00,0, 0,15'h0102,8'h66,0,0,0,16'd0));
    // start while busy is ignored: fill base 0x0300, 2 beats, seed 0x40
    vecs.push_back(mk(1,1,1,15'h0300,16'd2,8'h40,0, 0,15'h0102,8'h66,1,0,0,16'd0));
    vecs.push_back(mk(1,1,1,15'h0500,16'd3,8'h50,0, 1,15'h0300,8'h40,1,0,0,16'd1));
    vecs.push_back(mk(1,1,0,15'h0600,16'd5,8'h60,1, 1,15'h0301,8'h41,1,0,0,16'd2));
    vecs.push_back(mk(1,1,0,15'h0500,16'd5,8'h60,1, 0,15'h0301,8'h41,1,1,0,16'd2));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h00,0, 0,15'h0301,8'h41,0,0,0,16'd2));
    // Reset after 2 of 6 stream beats, then a fresh 1-beat fill at 0x0700
    vecs.push_back(mk(1,1,0,15'h0400,16'd6,8'h00,0, 0,15'h0301,8'h41,1,0,1,16'd0));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'hB1,1, 1,15'h0400,8'hB1,1,0,1,16'd1));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'hB2,1, 1,15'h0401,8'hB2,1,0,1,16'd2));
    vecs.push_back(mk(0,0,0,15'h0,16'd0,8'hB3,1, 0,15'h0000,8'h00,0,0,0,16'd0));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'hB4,1, 0,15'h0000,8'h00,0,0,0,16'd0));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h00,0, 0,15'h0000,8'h00,0,0,0,16'd0));
    vecs.push_back(mk(1,1,1,15'h0700,16'd1,8'h99,0, 0,15'h0000,8'h00,1,0,0,16'd0));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h00,0, 1,15'h0700,8'h99,1,0,0,16'd1));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h00,0, 0,15'h0700,8'h99,1,1,0,16'd1));
    vecs.push_back(mk(1,0,0,15'h0,16'd0,8'h00,0, 0,15'h0700,8'h99,0,0,0,16'd1));

    // Reset state
    rst = 1'b0; start = 1'b0; switch = 1'b0; base_addr = '0; length = '0;
    in_data = '0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rv = mk(0,0,0,15'h0,16'd0,8'h00,0, 0,15'h0000,8'h00,0,0,0,16'd0);
    chk_all(-1, rv);
    rst = 1'b1;

    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      start     = vecs[i].start;
      switch    = vecs[i].sw;
      base_addr = vecs[i].base;
      length    = vecs[i].len;
      in_data   = vecs[i].din;
      in_valid  = vecs[i].vld;
      @(posedge clk);
      #1;
      chk_all(i, vecs[i]);
    end

    // Clamp: fill length 0xFFFF from base 0 writes exactly 32768 beats
    rst = 1'b1; start = 1'b1; switch = 1'b1; base_addr = 15'h0000;
    length = 16'hFFFF; in_data = 8'h00; in_valid = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    writes = 0; bad_seq = 0; exp_a = 15'h0000; seen_done = 1'b0;
    last_a = '0; last_d = '0;
    for (int c = 0; c < 40000 && !seen_done; c++) begin
      @(posedge clk);
      #1;
      if (wr_en) begin
        if (address != exp_a || data != exp_a[7:0]) bad_seq++;
        exp_a  = exp_a + 15'd1;
        last_a = address;
        last_d = data;
        writes++;
      end
      if (done) seen_done = 1'b1;
    end
    n_vec++;
    chk("clamp_done_seen", 0, int'(seen_done), 1);
    chk("clamp_writes",    0, writes, 32768);
    chk("clamp_seq_errs",  0, bad_seq, 0);
    chk("clamp_count",     0, int'(count), 32'h8000);
    chk("clamp_last_addr", 0, int'(last_a), 32'h7FFF);
    chk("clamp_last_data", 0, int'(last_d), 32'hFF);
    @(posedge clk);
    #1;
    chk("clamp_idle_busy", 0, int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_writer.md
Name: ram_writer

Overview:
- Write-side companion to the 32K x 8 display/data RAM reader (15-bit address, 8-bit data).
- Accepts a byte stream over a valid/ready handshake, or generates an incrementing fill pattern.
- Writes each byte to consecutive RAM addresses from a programmable base, with address wrap-around, busy/done status and a beat counter.
- Sits between a byte source (loader/UART/test logic) and the RAM write port.

Parameters:
ADDR_W, 15, RAM address width
DATA_W, 8, RAM data width
LEN_W, 16, width of length/count (must hold 2**ADDR_W)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin a transfer; sampled in IDLE only
switch  in  1  mode, sampled at start: 0 = stream, 1 = fill pattern
base_addr  in  ADDR_W  first write address, latched at start
length  in  LEN_W  beats to write, latched at start; values > 2**ADDR_W clamp to 2**ADDR_W
in_data  in  DATA_W  stream byte; in fill mode, seed value latched at start
in_valid  in  1  stream byte valid
in_ready  out  1  writer can accept a byte this cycle
wr_en  out  1  RAM write strobe, registered
address  out  ADDR_W  RAM write address, registered
data  out  DATA_W  RAM write data, registered
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at transfer end
count  out  LEN_W  beats accepted in the current/last transfer

Behaviour:
- Reset (rst=0 at clock edge): state=IDLE; wr_en=0, address=0, data=0, done=0, count=0, busy=0, in_ready=0. Reset has priority over every other event, including mid-transfer; a write in flight is dropped and no further wr_en occurs.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - On start=1: latch base_addr into addr_reg, clamped length into len_reg, switch into mode, and in_data into pattern register (fill mode only).
  - Clear count; go to WRITE.
  - start while not IDLE is ignored.
- WRITE, acceptance:
  - Stream mode: in_ready = (count < len_reg), combinational from registers. Accept occurs when in_valid && in_ready.
  - Fill mode: in_ready=0, in_valid ignored, one implicit accept per cycle while count < len_reg.
- On accept at edge k:
  - In cycle k+1: wr_en=1, address=addr_reg, data = accepted byte (stream) or pattern (fill).
  - addr_reg increments modulo 2**ADDR_W (0x7FFF -> 0x0000). Pattern increments modulo 2**DATA_W. count increments.
  - No accept at edge k: wr_en=0 in cycle k+1; address/data hold their last values.
- WRITE exit: when count == len_reg at a clock edge, go to DONE.
  - Last write is therefore in the final WRITE cycle.
  - length=0: zero writes; WRITE lasts one cycle.
- DONE: done=1 for exactly one cycle, wr_en=0, then IDLE. count holds its final value until the next start.
- Throughput and latency:
  - Stream: 1 byte/cycle with continuous in_valid.
  - Fill: len cycles of writes.
  - start-to-first-wr_en = 2 cycles.
  - Last wr_en to done = 1 cycle.
- busy is high from the cycle after start through the DONE cycle inclusive.

Test Plan:
- Stream, base=0x0010, length=4, in_valid held high with bytes 0xA1..0xA4 -> wr_en high 4 consecutive cycles writing 0x0010..0x0013 <= 0xA1..0xA4; done pulses 1 cycle later; count=4; in_ready=0 after 4th accept.
- Wrap: base=0x7FFE, length=4, fill mode, seed 0xFE -> writes 0x7FFE<=0xFE, 0x7FFF<=0xFF, 0x0000<=0x00, 0x0001<=0x01; done once.
- Backpressure: stream length=3, in_valid pattern 1,0,0,1,0,1 -> exactly 3 wr_en pulses, each one cycle after its accept; address strictly sequential; no write on idle cycles.
- length=0 and length=0xFFFF -> length=0 gives no wr_en, done 2 cycles after start. Fill with length=0xFFFF clamps: exactly 32768 writes, count=0x8000, final address 0x7FFF when base=0.
- Reset mid-transfer: rst=0 for one edge after 2 of 6 beats -> next cycle busy=0, wr_en=0, count=0, no done. A new start then works normally from the new base.
- start asserted while busy with a different base -> ignored; the original transfer completes unchanged.
